pattern_tx: RTL and testbench
=============================

// Module: pattern_tx
// PURPOSE
//  Serial pattern transmitter: on a start request it shifts a latched W-bit pattern out MSB-first, one bit per clk.
//  Repeats the frame a programmable number of times, with a programmable idle gap between frames.
//  Drives the stimulus side of the serial sequence-detector path (default frame 11010).
// PARAMETERS
//  W    5        pattern width in bits (>=2)
//  RW   4        width of repeat_in
//  GW   4        width of gap_in
//  DEF  5'b11010 pattern loaded while pat_sel=0 (package constant)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   request; accepted only when IDLE
//  pat_sel     in   1   0: send DEF, 1: send pattern_in
//  pattern_in  in   W   user pattern, sampled at acceptance
//  repeat_in   in   RW  frames sent = repeat_in+1, sampled at acceptance
//  gap_in      in   GW  idle cycles between frames, sampled at acceptance
//  abort       in   1   terminate the transfer
//  out         out  1   serial data, registered
//  out_valid   out  1   out carries a frame bit (or parity bit)
//  frame_start out  1   high with first bit of each frame
//  busy        out  1   transfer in progress
//  done        out  1   1-cycle pulse after the last bit of the last frame
// BEHAVIOUR
//  Reset: state=IDLE; out=0, out_valid=0, frame_start=0, busy=0, done=0; internal counters cleared.
//  Priority per edge: reset > abort > start.
//  FSM states: IDLE, SHIFT, PAR (feature only), GAP, DONE.
//  IDLE: start=1 at edge E latches pattern/repeat/gap.
//    Same edge: out=pat[W-1], out_valid=1, frame_start=1, busy=1, go to SHIFT.
//    Latency: first bit visible the cycle after E.
//  SHIFT: bit index counts W-1 down to 0; one bit per cycle; frame_start is high only for the first bit.
//    After bit 0: go to PAR if the feature is enabled.
//    Otherwise, if frames remain: go to GAP, or directly into the next frame's MSB when gap=0.
//    Otherwise: go to DONE.
//  GAP: out=0, out_valid=0 for exactly gap cycles, then the next frame starts.
//    gap=0 gives back-to-back frames with no idle cycle.
//  DONE: done=1, busy=0, out_valid=0 for one cycle, then IDLE.
//    start is accepted in DONE? No: only in IDLE, so the earliest restart is the cycle after done.
//  start while busy or DONE: ignored; latched values are unchanged.
//  abort (any non-IDLE state): next edge gives IDLE, out_valid=0, busy=0, done NOT pulsed.
//  Repeat counter counts remaining frames down to 0; repeat_in=max sends 2^RW frames; no wrap.
//  reset mid-frame: identical to the reset values above; a partial frame is never completed.
// CONFIGURATION
//  PATTERN_TX_PARITY_EN defined:
//    after bit 0 of each frame, one extra cycle in PAR; out = even parity (XOR of the latched pattern), out_valid=1.
//    Frame length is W+1.
//  Undefined: PAR state and parity logic absent; frame length is W.
// STRUCTURE
//  Package pattern_tx_pkg: state enum, DEF pattern constant, state width.
//  One sub-module, pattern_tx_ctr: loadable down-counter with zero flag.
//    Instantiated three times: bit index, gap, repeat.
// TESTING
//  1. pat_sel=0, repeat=0, gap=0, start at cycle 0.
//     -> out 1,1,0,1,0 in cycles 1-5 with out_valid=1; done=1 in cycle 6; busy low.
//  2. repeat=1, gap=0.
//     -> 10 contiguous valid bits 1101011010; frame_start in cycles 1 and 6.
//  3. pat_sel=1, pattern_in=5'b10011, repeat=2, gap=3.
//     -> three frames, each separated by 3 out_valid=0 cycles; done after the 3rd frame.
//  4. abort during the 3rd bit.
//     -> out_valid=0 next cycle, no done; new start accepted the following cycle.
//  5. start re-pulsed mid-frame; reset asserted mid-frame.
//     -> start ignored, stream unchanged; on reset all outputs are 0 the next cycle.
//  6. PATTERN_TX_PARITY_EN with DEF pattern.
//     -> 6-bit frame 110101; loopback into the 11010 detector fires once per frame in all builds.

Source files
------------

// File: rtl/pattern_tx_pkg.sv
// rtl/pattern_tx_pkg.sv - shared state encoding and default frame for the serial pattern transmitter
package pattern_tx_pkg;

    localparam int STATE_W = 3;

    // Default frame recognised by the downstream serial sequence detector
    localparam logic [4:0] DEF_PATTERN = 5'b11010;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_PAR   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/pattern_tx_ctr.sv
// rtl/pattern_tx_ctr.sv - loadable down-counter with zero flag, used for bit index, gap and repeat
module pattern_tx_ctr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dec,
    output logic [N-1:0] count,
    output logic         zero
);

    // Load wins over decrement; decrement holds at zero so the counter never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial pattern transmitter, MSB-first frames with repeat and idle gap; PATTERN_TX_PARITY_EN adds an even-parity bit per frame
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int             W   = 5,
    parameter int             RW  = 4,
    parameter int             GW  = 4,
    parameter logic [W-1:0]   DEF = W'(DEF_PATTERN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pat_sel,
    input  logic [W-1:0]  pattern_in,
    input  logic [RW-1:0] repeat_in,
    input  logic [GW-1:0] gap_in,
    input  logic          abort,
    output logic          out,
    output logic          out_valid,
    output logic          frame_start,
    output logic          busy,
    output logic          done
);

    localparam int BW = $clog2(W);

    state_t        state;
    logic [W-1:0]  pat_q;
    logic [GW-1:0] gap_q;
    logic [W-1:0]  sel_pat;

    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [RW-1:0] rep_cnt;
    logic          bit_zero;
    logic          gap_zero;
    logic          rep_zero;

    logic accept;
    logic frame_end;
    logic more_frames;
    logic next_frame;
    logic bit_load;
    logic bit_dec;
    logic gap_load;
    logic gap_dec;
    logic rep_load;
    logic rep_dec;

    // Only the zero flags of the gap and repeat counters matter here
    logic unused_cnt;
    assign unused_cnt = ^{gap_cnt, rep_cnt};

    assign sel_pat = pat_sel ? pattern_in : DEF;

    // Sequencing events shared by the FSM and the three counters
    always_comb begin
        accept      = 1'b0;
        frame_end   = 1'b0;
        more_frames = 1'b0;
        next_frame  = 1'b0;
        bit_load    = 1'b0;
        bit_dec     = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        rep_load    = 1'b0;
        rep_dec     = 1'b0;

        accept = (state == ST_IDLE) && start;
`ifdef PATTERN_TX_PARITY_EN
        frame_end = (state == ST_PAR);
`else
        frame_end = (state == ST_SHIFT) && bit_zero;
`endif
        more_frames = frame_end && !rep_zero;
        next_frame  = (more_frames && (gap_q == '0)) || ((state == ST_GAP) && gap_zero);

        bit_load = accept || next_frame;
        bit_dec  = (state == ST_SHIFT) && !bit_zero;
        gap_load = more_frames && (gap_q != '0);
        gap_dec  = (state == ST_GAP) && !gap_zero;
        rep_load = accept;
        rep_dec  = more_frames;
    end

    pattern_tx_ctr #(.N(BW)) u_bit_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (bit_load),
        .load_val (BW'(W - 1)),
        .dec      (bit_dec),
        .count    (bit_cnt),
        .zero     (bit_zero)
    );

    // Loaded with gap-1 so the zero flag marks the final idle cycle
    pattern_tx_ctr #(.N(GW)) u_gap_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (gap_q - 1'b1),
        .dec      (gap_dec),
        .count    (gap_cnt),
        .zero     (gap_zero)
    );

    // Holds the number of frames still to send after the current one
    pattern_tx_ctr #(.N(RW)) u_rep_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (rep_load),
        .load_val (repeat_in),
        .dec      (rep_dec),
        .count    (rep_cnt),
        .zero     (rep_zero)
    );

    // Transmit FSM with registered serial outputs; reset beats abort beats start
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pat_q       <= '0;
            gap_q       <= '0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort && (state != ST_IDLE)) begin
            state       <= ST_IDLE;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (accept) begin
            pat_q       <= sel_pat;
            gap_q       <= gap_in;
            out         <= sel_pat[W-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_SHIFT;
        end else if (next_frame) begin
            out         <= pat_q[W-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
            state       <= ST_SHIFT;
        end else if (frame_end) begin
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (rep_zero) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
            end else begin
                state <= ST_GAP;
            end
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_SHIFT: begin
                    if (!bit_zero) begin
                        out <= pat_q[bit_cnt - 1'b1];
                    end
`ifdef PATTERN_TX_PARITY_EN
                    else begin
                        out   <= ^pat_q;
                        state <= ST_PAR;
                    end
`endif
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_GAP: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                end
                default: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - randomized self-checking bench for pattern_tx against a frame-level model
module tb_pattern_tx;

    localparam int         W   = 5;
    localparam int         RW  = 4;
    localparam int         GW  = 4;
    localparam logic [4:0] DEF = 5'b11010;

    logic          clk;
    logic          reset;
    logic          start;
    logic          pat_sel;
    logic [W-1:0]  pattern_in;
    logic [RW-1:0] repeat_in;
    logic [GW-1:0] gap_in;
    logic          abort;
    logic          out;
    logic          out_valid;
    logic          frame_start;
    logic          busy;
    logic          done;

    logic [4:0] obs;
    logic [4:0] exp_q[$];
    int tests;
    int failed;

    pattern_tx dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pat_sel     (pat_sel),
        .pattern_in  (pattern_in),
        .repeat_in   (repeat_in),
        .gap_in      (gap_in),
        .abort       (abort),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // {busy, done, out_valid, frame_start, out}
    assign obs = {busy, done, out_valid, frame_start, out};

    // Cycle-by-cycle expectation starting the cycle after start is accepted
    function automatic void build_expected(input logic [W-1:0] p, input int rep, input int gap);
        exp_q.delete();
        for (int f = 0; f <= rep; f++) begin
            if (f > 0) begin
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b10000);
            end
            for (int b = W - 1; b >= 0; b--) begin
                exp_q.push_back({1'b1, 1'b0, 1'b1, (b == W - 1), p[b]});
            end
`ifdef PATTERN_TX_PARITY_EN
            exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, ^p});
`endif
        end
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b00000);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (obs !== 5'b00000) begin
            failed++;
            $display("FAIL reset_held: got %b expected %b", obs, 5'b00000);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== 5'b00000) begin
            failed++;
            $display("FAIL reset_release: got %b expected %b", obs, 5'b00000);
        end
    endtask

    // First four iterations are the directed frames, the rest are random
    task automatic test_frames();
        logic          sels[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0]  pats[4] = '{5'b00000, 5'b11111, 5'b10011, 5'b01101};
        int            reps[4] = '{0, 1, 2, 15};
        int            gaps[4] = '{0, 0, 3, 0};
        logic          sel;
        logic [W-1:0]  p;
        int            rep;
        int            gap;
        for (int t = 0; t < 16; t++) begin
            if (t < 4) begin
                sel = sels[t]; p = pats[t]; rep = reps[t]; gap = gaps[t];
            end else begin
                sel = 1'($urandom);
                p   = W'($urandom);
                rep = int'($urandom_range(0, 3));
                gap = (t == 15) ? 15 : int'($urandom_range(0, 3));
            end
            @(negedge clk);
            pat_sel = sel; pattern_in = p; repeat_in = RW'(rep); gap_in = GW'(gap); start = 1'b1;
            build_expected(sel ? p : DEF, rep, gap);
            @(negedge clk);
            start = 1'b0;
            pat_sel = 1'($urandom); pattern_in = W'($urandom);
            repeat_in = RW'($urandom); gap_in = GW'($urandom);
            foreach (exp_q[i]) begin
                if (i > 0) @(negedge clk);
                tests++;
                if (obs !== exp_q[i]) begin
                    failed++;
                    $display("FAIL frames t%0d cycle %0d: got %b expected %b", t, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        pat_sel = 1'b1; pattern_in = 5'b10110; repeat_in = 4'd1; gap_in = 4'd2; start = 1'b1;
        build_expected(5'b10110, 1, 2);
        @(negedge clk);
        foreach (exp_q[i]) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (obs !== exp_q[i]) begin
                failed++;
                $display("FAIL start_ignored cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            if (i < exp_q.size() - 1) begin
                start = 1'($urandom); pat_sel = 1'($urandom); pattern_in = W'($urandom);
                repeat_in = RW'($urandom); gap_in = GW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] p2;
        @(negedge clk);
        pat_sel = 1'b0; repeat_in = 4'd2; gap_in = 4'd1; start = 1'b1;
        build_expected(DEF, 2, 1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (obs !== exp_q[i]) begin
                failed++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (obs !== 5'b00000) begin
            failed++;
            $display("FAIL abort_idle: got %b expected %b", obs, 5'b00000);
        end
        p2 = W'($urandom);
        pat_sel = 1'b1; pattern_in = p2; repeat_in = 4'd0; gap_in = 4'd0; start = 1'b1;
        build_expected(p2, 0, 0);
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[i]) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (obs !== exp_q[i]) begin
                failed++;
                $display("FAIL abort_restart cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pat_sel = 1'b0; repeat_in = 4'd2; gap_in = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; abort = 1'b1; start = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== 5'b00000) begin
            failed++;
            $display("FAIL reset_mid: got %b expected %b", obs, 5'b00000);
        end
        reset = 1'b0; abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== 5'b00000) begin
                failed++;
                $display("FAIL reset_mid_quiet cycle %0d: got %b expected %b", i, obs, 5'b00000);
            end
        end
    endtask

    // Sliding-window 11010 detector fed with the valid serial bits
    task automatic test_loopback();
        logic [4:0] win;
        int nbits;
        int hits;
        int gap;
        bit seen_done;
        for (int t = 0; t < 3; t++) begin
            gap = (t == 0) ? 0 : int'($urandom_range(1, 3));
            win = '0; nbits = 0; hits = 0; seen_done = 0;
            @(negedge clk);
            pat_sel = 1'b0; repeat_in = 4'd3; gap_in = GW'(gap); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 200 && !seen_done; c++) begin
                if (c > 0) @(negedge clk);
                if (out_valid) begin
                    win = {win[3:0], out};
                    nbits++;
                    if (nbits >= 5 && win == DEF) hits++;
                end
                if (done) seen_done = 1;
            end
            tests++;
            if (!seen_done) begin
                failed++;
                $display("FAIL loopback_timeout t%0d: got done=0 expected done=1", t);
            end
            tests++;
            if (hits != 4) begin
                failed++;
                $display("FAIL loopback_hits t%0d: got %0d expected %0d", t, hits, 4);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; start = 1'b0; pat_sel = 1'b0;
        pattern_in = '0; repeat_in = '0; gap_in = '0; abort = 1'b0;
        tests = 0; failed = 0;
        test_reset();
        test_frames();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
